// File: rtl/program_loader_pkg.sv
// Shared state encoding and default sizing for the program loader.
package program_loader_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT
    } state_t;
endpackage

// File: rtl/program_loader_mem.sv
// Program store: one synchronous write port, one registered read port.
module prog_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register holds its value when not enabled (HALT keeps last instruction).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/program_loader.sv
// Loads bytes from the input buffer into program memory, then fetches by PC until past the end.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    input  logic              start,
    input  logic              clear,
    input  logic [PC_W-1:0]   pc,
    output logic              pc_inc,
    output logic [WIDTH-1:0]  instr,
    output logic              instr_valid,
    output logic [ADDR_W:0]   load_count,
    output logic              full,
    output logic              overflow,
    output logic [1:0]        state
);
    localparam int CMP_W = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;

    state_t          state_q, state_d;
    logic            in_prev;
    logic [ADDR_W:0] count_q;
    logic            ovf_q;
    logic            iv_q;
    logic            new_byte, load_mode, run_mode, pc_in_prog, we;

    assign new_byte   = in_valid & ~in_prev;
    assign run_mode   = (state_q == S_RUN);
    // The unused encoding behaves exactly like LOAD.
    assign load_mode  = (state_q != S_RUN) && (state_q != S_HALT);
    assign full       = (count_q == (ADDR_W+1)'(DEPTH));
    assign pc_in_prog = CMP_W'(pc) < CMP_W'(count_q);
    assign we         = load_mode && new_byte && !full && !clear;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (!pc_in_prog) state_d = S_HALT;
            S_HALT:  if (start) state_d = S_RUN;
            default: begin
                state_d = S_LOAD;
                if (start && count_q != '0) state_d = S_RUN;
            end
        endcase
        if (clear) state_d = S_LOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
            in_prev <= 1'b1;
            count_q <= '0;
            ovf_q   <= 1'b0;
            iv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            in_prev <= in_valid;
            if (clear) begin
                count_q <= '0;
                ovf_q   <= 1'b0;
                iv_q    <= 1'b0;
            end else begin
                if (we) count_q <= count_q + 1'b1;
                if (load_mode && new_byte && full) ovf_q <= 1'b1;
                iv_q <= run_mode && pc_in_prog;
            end
        end
    end

    // Write pointer equals the count: it only returns to zero through clear.
    prog_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata (in_data),
        .re    (run_mode),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (instr)
    );

    assign pc_inc      = run_mode;
    assign instr_valid = iv_q;
    assign load_count  = count_q;
    assign overflow    = ovf_q;
    assign state       = state_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: directed table, corner sequences, randomized run against a queue-level model.
module tb_program_loader;
    logic       clk = 0;
    logic       rst = 0;
    logic [7:0] in_data = 0;
    logic       in_valid = 0;
    logic       start = 0;
    logic       clear = 0;
    logic [7:0] pc = 0;
    logic       pc_inc;
    logic [7:0] instr;
    logic       instr_valid;
    logic [4:0] load_count;
    logic       full;
    logic       overflow;
    logic [1:0] state;

    program_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .start(start), .clear(clear), .pc(pc), .pc_inc(pc_inc),
        .instr(instr), .instr_valid(instr_valid), .load_count(load_count),
        .full(full), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference model: program bytes, mode, and the flags seen by the outside world.
    logic [7:0] m_mem [16];
    int         m_cnt;
    int         m_state;
    logic       m_ovf, m_iv, m_prev;
    logic [7:0] m_instr;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       st;
        logic       cl;
        logic [7:0] pc;
        int         e_state;
        int         e_cnt;
        logic       e_iv;
        logic [7:0] e_instr;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [7:0] d, logic st, logic [7:0] p,
                                int es, int ec, logic eiv, logic [7:0] ei);
        vec_t v;
        v.iv = iv; v.d = d; v.st = st; v.cl = 1'b0; v.pc = p;
        v.e_state = es; v.e_cnt = ec; v.e_iv = eiv; v.e_instr = ei;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_state = 0; m_ovf = 0; m_iv = 0; m_prev = 1; m_instr = 0;
    endtask

    task automatic model_step(logic iv, logic [7:0] d, logic st, logic cl, logic [7:0] p);
        logic nb;
        int   old_cnt;
        nb = iv && !m_prev;
        m_prev = iv;
        old_cnt = m_cnt;
        if (cl) begin
            m_cnt = 0; m_ovf = 0; m_state = 0; m_iv = 0;
        end else if (m_state == 1) begin
            m_iv = (int'(p) < m_cnt);
            m_instr = m_mem[p % 16];
            if (int'(p) >= m_cnt) m_state = 2;
        end else if (m_state == 2) begin
            m_iv = 0;
            if (st) m_state = 1;
        end else begin
            if (nb) begin
                if (m_cnt < 16) begin m_mem[m_cnt] = d; m_cnt++; end
                else m_ovf = 1;
            end
            if (st && old_cnt > 0) m_state = 1;
            m_iv = 0;
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, "_state"}, 32'(state), 32'(m_state));
        chk({tag, "_count"}, 32'(load_count), 32'(m_cnt));
        chk({tag, "_full"}, 32'(full), 32'(m_cnt == 16));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_pcinc"}, 32'(pc_inc), 32'(m_state == 1));
        chk({tag, "_ivalid"}, 32'(instr_valid), 32'(m_iv));
        if (m_iv) chk({tag, "_instr"}, 32'(instr), 32'(m_instr));
    endtask

    task automatic cyc(string tag, logic iv, logic [7:0] d, logic st, logic cl, logic [7:0] p);
        in_valid = iv; in_data = d; start = st; clear = cl; pc = p;
        model_step(iv, d, st, cl, p);
        @(posedge clk); #1;
        check_model(tag);
    endtask

    task automatic load_byte(string tag, logic [7:0] d);
        cyc(tag, 1'b1, d, 1'b0, 1'b0, 8'd0);
        cyc(tag, 1'b0, d, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        logic       r_iv;
        logic [7:0] b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(load_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_ivalid", 32'(instr_valid), 0);
        chk("rst_pcinc", 32'(pc_inc), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_full", 32'(full), 0);
        #2 rst = 1;

        // Tests 1-2: three held bytes, then run through pc 0..3
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
        b0 = 8'hA1;
        for (int b = 0; b < 3; b++) begin
            for (int h = 0; h < 4; h++) tbl.push_back(mk(1, b0, 0, 0, 0, b + 1, 0, 0));
            tbl.push_back(mk(0, 8'h00, 0, 0, 0, b + 1, 0, 0));
            b0 = b0 + 8'h11;
        end
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 3, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 3, 1, 8'hA1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 3, 1, 8'hB2));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 3, 1, 8'hC3));
        tbl.push_back(mk(0, 8'h00, 0, 3, 2, 3, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 3, 2, 3, 0, 0));
        foreach (tbl[i]) begin
            cyc("tbl", tbl[i].iv, tbl[i].d, tbl[i].st, tbl[i].cl, tbl[i].pc);
            chk("tbl_state", 32'(state), 32'(tbl[i].e_state));
            chk("tbl_count", 32'(load_count), 32'(tbl[i].e_cnt));
            chk("tbl_ivalid", 32'(instr_valid), 32'(tbl[i].e_iv));
            chk("tbl_full", 32'(full), 0);
            if (tbl[i].e_iv) chk("tbl_instr", 32'(instr), 32'(tbl[i].e_instr));
        end
        chk("t2_pcinc_halt", 32'(pc_inc), 0);

        // Test 3: fill, overflow, mem[0] intact, clear
        cyc("t3", 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) load_byte("t3", 8'h40 + 8'(i));
        chk("t3_full16", 32'(full), 1);
        chk("t3_noovf", 32'(overflow), 0);
        load_byte("t3", 8'hEE);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_count16", 32'(load_count), 16);
        cyc("t3", 0, 0, 1, 0, 0);
        cyc("t3", 0, 0, 0, 0, 0);
        chk("t3_mem0", 32'(instr), 32'h40);
        cyc("t3", 0, 0, 0, 0, 16);
        chk("t3_halt", 32'(state), 2);
        cyc("t3", 0, 0, 0, 1, 0);
        chk("t3_clr_count", 32'(load_count), 0);
        chk("t3_clr_ovf", 32'(overflow), 0);
        chk("t3_clr_state", 32'(state), 0);

        // Test 4: start with nothing loaded
        cyc("t4", 0, 0, 1, 0, 0);
        chk("t4_state", 32'(state), 0);
        chk("t4_pcinc", 32'(pc_inc), 0);

        // Test 5: start and clear together
        load_byte("t5", 8'h11);
        load_byte("t5", 8'h22);
        cyc("t5", 0, 0, 1, 1, 0);
        chk("t5_state", 32'(state), 0);
        chk("t5_count", 32'(load_count), 0);

        // Test 6: async reset mid-RUN, in_valid high through release
        load_byte("t6", 8'h33);
        load_byte("t6", 8'h44);
        cyc("t6", 0, 0, 1, 0, 0);
        cyc("t6", 0, 0, 0, 0, 0);
        chk("t6_running", 32'(instr_valid), 1);
        in_valid = 1;
        #3 rst = 0;
        #1;
        chk("t6_state", 32'(state), 0);
        chk("t6_pcinc", 32'(pc_inc), 0);
        chk("t6_ivalid", 32'(instr_valid), 0);
        chk("t6_count", 32'(load_count), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1;
        for (int i = 0; i < 3; i++) cyc("t6", 1, 8'h55, 0, 0, 0);
        chk("t6_nowrite", 32'(load_count), 0);

        // Randomized traffic against the model
        r_iv = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) r_iv = ~r_iv;
            cyc("rnd", r_iv, 8'($urandom), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 59) == 0), 8'($urandom_range(0, 19)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
